// File: rtl/ptw_module.sv
`default_nettype none
// ============================================================================
// Module   : ptw_module
// Purpose  : Sv32 two-level hardware page-table walker that fills the L2TLB
//            and reports translation / page-fault / access-fault results.
// Revision : 1.0 - initial release
// ============================================================================
module ptw_module #(
  parameter int PTE_WIDTH      = 32,
  parameter int PHY_ADDR_WIDTH = 34,
  parameter int VADDR_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ptw_req_vld,
  output logic                      o_ptw_req_rdy,
  input  logic [VADDR_WIDTH-1:0]    i_ptw_vaddr,
  input  logic [31:0]               i_ptw_satp,
  input  logic                      i_ptw_flush,
  output logic                      o_ptw_mem_req_vld,
  output logic [PHY_ADDR_WIDTH-1:0] o_ptw_mem_req_addr,
  input  logic                      i_ptw_mem_req_rdy,
  input  logic                      i_ptw_mem_rsp_vld,
  input  logic [PTE_WIDTH-1:0]      i_ptw_mem_rsp_data,
  input  logic                      i_ptw_mem_rsp_err,
  output logic                      o_ptw_l2tlb_wren,
  output logic [VADDR_WIDTH-1:0]    o_ptw_l2tlb_vaddr,
  output logic [PTE_WIDTH-1:0]      o_ptw_l2tlb_pte,
  output logic [PHY_ADDR_WIDTH-1:0] o_ptw_l2tlb_paddr,
  output logic                      o_ptw_done,
  output logic                      o_ptw_page_fault,
  output logic                      o_ptw_access_fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_RESP    = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [VADDR_WIDTH-1:0]    r_vaddr;
  logic [PHY_ADDR_WIDTH-1:0] r_mem_addr;
  logic [PTE_WIDTH-1:0]      r_pte;
  logic [PHY_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_success;
  logic                      r_page_fault;
  logic                      r_access_fault;

  logic                      w_accept;
  logic                      w_grant;
  logic                      w_pte_v;
  logic                      w_pte_r;
  logic                      w_pte_w;
  logic                      w_pte_x;
  logic                      w_pte_bad;
  logic                      w_pte_leaf;
  logic                      w_pte_misaligned;
  logic [PHY_ADDR_WIDTH-1:0] w_l1_addr;
  logic [PHY_ADDR_WIDTH-1:0] w_l0_addr;
  logic [PHY_ADDR_WIDTH-1:0] w_super_paddr;
  logic [PHY_ADDR_WIDTH-1:0] w_page_paddr;
  logic                      w_load_l0;
  logic                      w_set_result;
  logic                      w_res_ok;
  logic                      w_res_pf;
  logic                      w_res_af;
  logic [PHY_ADDR_WIDTH-1:0] w_res_paddr;
  logic                      w_in_resp;
  logic                      w_fill;
  logic                      w_unused_satp;

  // satp mode/ASID fields play no part in the walk itself
  assign w_unused_satp = ^i_ptw_satp[31:22];

  assign w_accept = i_ptw_req_vld & o_ptw_req_rdy;
  assign w_grant  = o_ptw_mem_req_vld & i_ptw_mem_req_rdy;

  assign w_pte_v          = i_ptw_mem_rsp_data[0];
  assign w_pte_r          = i_ptw_mem_rsp_data[1];
  assign w_pte_w          = i_ptw_mem_rsp_data[2];
  assign w_pte_x          = i_ptw_mem_rsp_data[3];
  assign w_pte_bad        = ~w_pte_v | (~w_pte_r & w_pte_w);
  assign w_pte_leaf       = w_pte_r | w_pte_x;
  assign w_pte_misaligned = |i_ptw_mem_rsp_data[19:10];

  assign w_l1_addr     = {i_ptw_satp[21:0], 12'b0} + {22'b0, i_ptw_vaddr[31:22], 2'b0};
  assign w_l0_addr     = {i_ptw_mem_rsp_data[31:10], 12'b0} + {22'b0, r_vaddr[21:12], 2'b0};
  assign w_super_paddr = {i_ptw_mem_rsp_data[31:20], r_vaddr[21:0]};
  assign w_page_paddr  = {i_ptw_mem_rsp_data[31:10], r_vaddr[11:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_l0    = 1'b0;
    w_set_result = 1'b0;
    w_res_ok     = 1'b0;
    w_res_pf     = 1'b0;
    w_res_af     = 1'b0;
    w_res_paddr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_L1_REQ;
      end
      S_L1_REQ: begin
        // a request granted in the flush cycle still owes us a response
        if (i_ptw_flush)  w_state_next = w_grant ? S_DRAIN : S_IDLE;
        else if (w_grant) w_state_next = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        if (i_ptw_flush) begin
          w_state_next = i_ptw_mem_rsp_vld ? S_IDLE : S_DRAIN;
        end else if (i_ptw_mem_rsp_vld) begin
          w_state_next = S_RESP;
          w_set_result = 1'b1;
          if (i_ptw_mem_rsp_err) begin
            w_res_af = 1'b1;
          end else if (w_pte_bad) begin
            w_res_pf = 1'b1;
          end else if (w_pte_leaf) begin
            w_res_pf    = w_pte_misaligned;
            w_res_ok    = ~w_pte_misaligned;
            w_res_paddr = w_super_paddr;
          end else begin
            w_state_next = S_L0_REQ;
            w_set_result = 1'b0;
            w_load_l0    = 1'b1;
          end
        end
      end
      S_L0_REQ: begin
        if (i_ptw_flush)  w_state_next = w_grant ? S_DRAIN : S_IDLE;
        else if (w_grant) w_state_next = S_L0_WAIT;
      end
      S_L0_WAIT: begin
        if (i_ptw_flush) begin
          w_state_next = i_ptw_mem_rsp_vld ? S_IDLE : S_DRAIN;
        end else if (i_ptw_mem_rsp_vld) begin
          w_state_next = S_RESP;
          w_set_result = 1'b1;
          if (i_ptw_mem_rsp_err) begin
            w_res_af = 1'b1;
          end else if (w_pte_bad | ~w_pte_leaf) begin
            w_res_pf = 1'b1;
          end else begin
            w_res_ok    = 1'b1;
            w_res_paddr = w_page_paddr;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (i_ptw_mem_rsp_vld) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vaddr        <= '0;
      r_mem_addr     <= '0;
      r_pte          <= '0;
      r_paddr        <= '0;
      r_success      <= 1'b0;
      r_page_fault   <= 1'b0;
      r_access_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vaddr    <= i_ptw_vaddr;
        r_mem_addr <= w_l1_addr;
      end
      if (w_load_l0) begin
        r_mem_addr <= w_l0_addr;
      end
      if (w_set_result) begin
        r_pte          <= i_ptw_mem_rsp_data;
        r_paddr        <= w_res_paddr;
        r_success      <= w_res_ok;
        r_page_fault   <= w_res_pf;
        r_access_fault <= w_res_af;
      end
    end
  end

  assign w_in_resp = (r_state == S_RESP);
  assign w_fill    = w_in_resp & r_success;

  assign o_ptw_req_rdy      = (r_state == S_IDLE) & ~i_ptw_flush;
  assign o_ptw_mem_req_vld  = (r_state == S_L1_REQ) | (r_state == S_L0_REQ);
  assign o_ptw_mem_req_addr = o_ptw_mem_req_vld ? r_mem_addr : '0;

  assign o_ptw_done         = w_in_resp;
  assign o_ptw_page_fault   = w_in_resp & r_page_fault;
  assign o_ptw_access_fault = w_in_resp & r_access_fault;
  assign o_ptw_l2tlb_wren   = w_fill;
  assign o_ptw_l2tlb_vaddr  = w_fill ? r_vaddr : '0;
  assign o_ptw_l2tlb_pte    = w_fill ? r_pte : '0;
  assign o_ptw_l2tlb_paddr  = w_fill ? r_paddr : '0;

endmodule
`default_nettype wire
